usr_serdes_ctrl: RTL and testbench
==================================

Name: usr_serdes_ctrl

Overview:
Controller that sequences a universal shift register (hold / shift-right / shift-left / parallel-load) and shares it between two requesters.
- Transmit requester: parallel word in, serial bits out.
- Receive requester: serial bits in, parallel word out.
- Arbitrates TX/RX access and counts shifts.
- Sits between a byte/nibble-level producer/consumer and a single-wire serial link.

Parameters:
WIDTH, 4, shift register and data word width; legal range 2..32.
CNT_W, $clog2(WIDTH), shift counter width (derived, not overridden).

Ports:
clk        input   1      rising-edge clock
reset      input   1      asynchronous, active-high reset
ld_valid   input   1      TX word offered
ld_ready   output  1      controller accepts TX word (high only in IDLE)
ld_data    input   WIDTH  TX parallel word
tx_dir     input   1      0 = LSB first (shift right), 1 = MSB first (shift left); sampled with ld_data
rx_start   input   1      request to receive one WIDTH-bit word
rx_dir     input   1      0 = s_in enters MSB (shift right), 1 = s_in enters LSB (shift left); sampled with rx_start
s_in       input   1      serial receive bit
s_out      output  1      serial transmit bit
s_out_valid output 1      s_out carries a valid bit this cycle
rx_data    output  WIDTH  received word (register contents)
rx_valid   output  1      rx_data complete
rx_ready   input   1      consumer takes rx_data
sr_op      output  2      operation applied at next edge: 00 hold, 01 shr, 10 shl, 11 load
busy       output  1      state != IDLE

Behaviour:
- Reset (asynchronous, active-high) sets:
  - state=IDLE; reg=0; cnt=0; dir_q=0; last_grant=RX.
  - All outputs low; rx_data=0; sr_op=00.
- Reset mid-transfer aborts immediately; any partially sent or received word is discarded.
- Shift fill: 0 shifts in during TX; s_in shifts in during RX.
- IDLE:
  - ld_ready=1; sr_op=00.
  - Only ld_valid high: load. sr_op=11, reg<=ld_data, dir_q<=tx_dir, cnt<=0, next TX_SHIFT.
  - Only rx_start high: rx grant. dir_q<=rx_dir, cnt<=0, next RX_SHIFT.
  - Both high: grant the requester not equal to last_grant, then update last_grant. First tie after reset goes to TX.
- TX_SHIFT:
  - s_out_valid=1.
  - s_out = reg[0] if dir_q=0, else reg[WIDTH-1].
  - sr_op = 01 (dir_q=0) or 10 (dir_q=1); zero fill.
  - cnt increments each cycle.
  - When cnt==WIDTH-1: return to IDLE.
  - Exactly WIDTH valid bits; ld_data is accepted on the cycle before the first bit.
- RX_SHIFT:
  - sr_op = 01 (s_in into MSB) or 10 (s_in into LSB); s_in is sampled every cycle.
  - When cnt==WIDTH-1: shift the last bit in, go to RX_HOLD.
- RX_HOLD:
  - rx_valid=1; sr_op=00; rx_data stable.
  - When rx_ready is high: go to IDLE; rx_valid drops next cycle.
  - No new grant while holding; ld_valid and rx_start are ignored.
- rx_data always equals reg. It is meaningful only while rx_valid is high.
- Back-to-back transfers: an IDLE cycle always separates operations. Throughput is WIDTH+1 cycles per TX word and WIDTH+1+handshake cycles per RX word.
- Requests arriving while busy are not queued; the requester keeps its request asserted.

Decomposition:
- Shared package usr_pkg:
  - Op code constants OP_HOLD=2'b00, OP_SHR=2'b01, OP_SHL=2'b10, OP_LOAD=2'b11.
  - State encoding IDLE, TX_SHIFT, RX_SHIFT, RX_HOLD.
  - Grant enum TX/RX.
- One sub-module, usr_core: the WIDTH-parameterised universal shift register (clk, reset, s_in, p_in, op, q).
  - The controller drives op, p_in and the fill bit.
  - The controller reads q for s_out and rx_data.

Test Plan:
1. TX LSB-first, WIDTH=4: ld_data=4'b1011, tx_dir=0 -> one load cycle (sr_op=11), then s_out_valid high 4 cycles with s_out=1,1,0,1, sr_op=01 each; ld_ready low those 4 cycles.
2. TX MSB-first: ld_data=4'b1011, tx_dir=1 -> s_out=1,0,1,1 over 4 cycles; sr_op=10; busy low on the 5th cycle after load.
3. RX: rx_start with rx_dir=0, s_in=1,1,0,0 -> rx_data=4'b0011, rx_valid high. With rx_dir=1 and the same bits -> 4'b1100. Holding rx_ready low for 3 cycles keeps rx_valid and rx_data stable; rx_ready high -> IDLE.
4. Arbitration:
   - ld_valid and rx_start both high right after reset -> TX granted.
   - Next tie -> RX granted.
   - Next tie -> TX granted.
   - ld_valid during RX_HOLD -> ignored until IDLE.
5. Reset mid-TX: assert reset after 2 of 4 bits -> same cycle s_out_valid=0, busy=0; register reads 0. After release, a new load of 4'b0110 sends 0,1,1,0 correctly.
6. Boundary WIDTH=2 and WIDTH=8: TX 8'hA5 LSB-first -> 1,0,1,0,0,1,0,1; the counter wraps exactly at WIDTH-1 with no extra valid bit.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the serdes controller: shift-register op codes,
// controller state encoding and the arbitration grant type.
package usr_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TX_SHIFT = 2'd1,
        RX_SHIFT = 2'd2,
        RX_HOLD  = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_TX = 1'b0,
        GRANT_RX = 1'b1
    } grant_t;

endpackage

// File: rtl/usr_core.sv
// WIDTH-bit universal shift register: hold, shift right (fill into MSB),
// shift left (fill into LSB) or parallel load.
module usr_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            case (op)
                OP_SHR:  r_q <= {s_in, r_q[WIDTH-1:1]};
                OP_SHL:  r_q <= {r_q[WIDTH-2:0], s_in};
                OP_LOAD: r_q <= p_in;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: rtl/usr_serdes_ctrl.sv
// Sequences a shared universal shift register between a parallel-in/serial-out
// transmitter and a serial-in/parallel-out receiver with alternating tie-break.
module usr_serdes_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             tx_dir,
    input  logic             rx_start,
    input  logic             rx_dir,
    input  logic             s_in,
    output logic             s_out,
    output logic             s_out_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [1:0]       sr_op,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_dir_q, w_dir_next;
    grant_t           r_last_grant, w_last_next;
    logic [1:0]       w_op;
    logic             w_fill;
    logic             w_tx_grant, w_rx_grant;
    logic [WIDTH-1:0] w_q;

    usr_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .s_in  (w_fill),
        .p_in  (ld_data),
        .op    (w_op),
        .q     (w_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_dir_q      <= 1'b0;
            r_last_grant <= GRANT_RX;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= w_cnt_next;
            r_dir_q      <= w_dir_next;
            r_last_grant <= w_last_next;
        end
    end

    // On a tie the requester that did not win the previous tie is served.
    assign w_tx_grant = ld_valid && (!rx_start || (r_last_grant == GRANT_RX));
    assign w_rx_grant = rx_start && !w_tx_grant;

    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_dir_next   = r_dir_q;
        w_last_next  = r_last_grant;
        w_op         = OP_HOLD;
        w_fill       = 1'b0;
        s_out        = 1'b0;
        s_out_valid  = 1'b0;
        rx_valid     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_tx_grant) begin
                    w_op         = OP_LOAD;
                    w_dir_next   = tx_dir;
                    w_cnt_next   = '0;
                    w_next_state = TX_SHIFT;
                end else if (w_rx_grant) begin
                    w_dir_next   = rx_dir;
                    w_cnt_next   = '0;
                    w_next_state = RX_SHIFT;
                end
                if (ld_valid && rx_start) begin
                    w_last_next = w_tx_grant ? GRANT_TX : GRANT_RX;
                end
            end
            TX_SHIFT, RX_SHIFT: begin
                w_op = r_dir_q ? OP_SHL : OP_SHR;
                if (r_state == TX_SHIFT) begin
                    s_out_valid = 1'b1;
                    s_out       = r_dir_q ? w_q[WIDTH-1] : w_q[0];
                end else begin
                    w_fill = s_in;
                end
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = '0;
                    w_next_state = (r_state == TX_SHIFT) ? IDLE : RX_HOLD;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            RX_HOLD: begin
                rx_valid = 1'b1;
                if (rx_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs that depend on live inputs are forced low while reset is held.
    assign ld_ready = (r_state == IDLE) && !reset;
    assign sr_op    = reset ? OP_HOLD : w_op;
    assign busy     = (r_state != IDLE);
    assign rx_data  = w_q;

endmodule

// File: tb/tb_usr_serdes_ctrl.sv
// Self-checking bench for usr_serdes_ctrl: directed vector table, corner
// sequences, WIDTH=8/2 boundaries and a randomized transaction-level model.
module tb_usr_serdes_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_valid, tx_dir, rx_start, rx_dir, s_in, rx_ready;
    logic [3:0] ld_data;
    logic       ld_ready, s_out, s_out_valid, rx_valid, busy;
    logic [3:0] rx_data;
    logic [1:0] sr_op;

    logic       ld_valid8, tx_dir8;
    logic [7:0] ld_data8, rx_data8;
    logic       ld_ready8, s_out8, s_out_valid8, rx_valid8, busy8;
    logic [1:0] sr_op8;

    logic       ld_valid2, tx_dir2;
    logic [1:0] ld_data2, rx_data2;
    logic       ld_ready2, s_out2, s_out_valid2, rx_valid2, busy2;
    logic [1:0] sr_op2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    usr_serdes_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .tx_dir(tx_dir), .rx_start(rx_start), .rx_dir(rx_dir),
        .s_in(s_in), .s_out(s_out), .s_out_valid(s_out_valid), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .sr_op(sr_op), .busy(busy)
    );

    usr_serdes_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .ld_valid(ld_valid8), .ld_ready(ld_ready8),
        .ld_data(ld_data8), .tx_dir(tx_dir8), .rx_start(1'b0), .rx_dir(1'b0),
        .s_in(1'b0), .s_out(s_out8), .s_out_valid(s_out_valid8), .rx_data(rx_data8),
        .rx_valid(rx_valid8), .rx_ready(1'b0), .sr_op(sr_op8), .busy(busy8)
    );

    usr_serdes_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .ld_valid(ld_valid2), .ld_ready(ld_ready2),
        .ld_data(ld_data2), .tx_dir(tx_dir2), .rx_start(1'b0), .rx_dir(1'b0),
        .s_in(1'b0), .s_out(s_out2), .s_out_valid(s_out_valid2), .rx_data(rx_data2),
        .rx_valid(rx_valid2), .rx_ready(1'b0), .sr_op(sr_op2), .busy(busy2)
    );

    typedef struct {
        bit         is_rx;
        bit         dir;
        logic [3:0] din;   // TX: parallel word; RX: serial bits, index = arrival order
        logic [3:0] exp;   // TX: sent bits, index = send order; RX: received word
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_tx4(input logic [3:0] data, input bit dir, input logic [3:0] exp);
        ld_valid = 1'b1;
        ld_data  = data;
        tx_dir   = dir;
        @(negedge clk);
        check("tx_load_op", 32'(sr_op), 32'd3);
        check("tx_load_ready", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("tx_valid", 32'(s_out_valid), 32'd1);
            check("tx_bit", 32'(s_out), 32'(exp[k]));
            check("tx_op", 32'(sr_op), dir ? 32'd2 : 32'd1);
            check("tx_ready_low", 32'(ld_ready), 32'd0);
            tick();
        end
        @(negedge clk);
        check("tx_done_busy", 32'(busy), 32'd0);
        check("tx_done_valid", 32'(s_out_valid), 32'd0);
        tick();
    endtask

    task automatic run_rx4(input logic [3:0] bits, input bit dir, input logic [3:0] exp,
                           input int hold);
        rx_start = 1'b1;
        rx_dir   = dir;
        @(negedge clk);
        check("rx_grant_op", 32'(sr_op), 32'd0);
        tick();
        rx_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_in = bits[k];
            @(negedge clk);
            check("rx_op", 32'(sr_op), dir ? 32'd2 : 32'd1);
            check("rx_valid_low", 32'(rx_valid), 32'd0);
            tick();
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("rx_hold_valid", 32'(rx_valid), 32'd1);
            check("rx_hold_data", 32'(rx_data), 32'(exp));
            check("rx_hold_op", 32'(sr_op), 32'd0);
            tick();
        end
        rx_ready = 1'b1;
        @(negedge clk);
        check("rx_take_valid", 32'(rx_valid), 32'd1);
        check("rx_take_data", 32'(rx_data), 32'(exp));
        tick();
        rx_ready = 1'b0;
        @(negedge clk);
        check("rx_done_valid", 32'(rx_valid), 32'd0);
        check("rx_done_busy", 32'(busy), 32'd0);
        tick();
    endtask

    // Transaction-level reference model for the randomized phase.
    int         m_mode;      // 0 idle, 1 sending, 2 receiving, 3 word waiting
    bit         m_dir;
    bit         m_last_rx;   // last tie went to the receiver
    bit         q_tx[$];
    bit         q_rx[$];
    logic [3:0] m_word;

    initial begin
        logic [3:0] b;
        logic [7:0] w8;
        logic [1:0] w2;

        vecs[0] = '{1'b0, 1'b0, 4'b1011, 4'b1011};
        vecs[1] = '{1'b0, 1'b1, 4'b1011, 4'b1101};
        vecs[2] = '{1'b0, 1'b0, 4'b0110, 4'b0110};
        vecs[3] = '{1'b0, 1'b1, 4'b0001, 4'b1000};
        vecs[4] = '{1'b1, 1'b0, 4'b0011, 4'b0011};
        vecs[5] = '{1'b1, 1'b1, 4'b0011, 4'b1100};
        vecs[6] = '{1'b1, 1'b0, 4'b0001, 4'b0001};
        vecs[7] = '{1'b1, 1'b1, 4'b0001, 4'b1000};

        reset = 1'b1;
        {ld_valid, tx_dir, rx_start, rx_dir, s_in, rx_ready} = '0;
        ld_data = '0;
        {ld_valid8, tx_dir8, ld_valid2, tx_dir2} = '0;
        ld_data8 = '0;
        ld_data2 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({ld_ready, s_out, s_out_valid, rx_valid, busy, sr_op}), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        reset = 1'b0;
        tick();
        @(negedge clk);
        check("post_rst_ready", 32'(ld_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        tick();

        // Arbitration: TX, then RX, then TX on successive ties
        ld_valid = 1'b1; rx_start = 1'b1; ld_data = 4'b1011; tx_dir = 1'b0; rx_dir = 1'b0;
        @(negedge clk);
        check("arb1_tx_load", 32'(sr_op), 32'd3);
        tick();
        ld_valid = 1'b0; rx_start = 1'b0;
        @(negedge clk);
        check("arb1_tx_shift", 32'(s_out_valid), 32'd1);
        repeat (4) tick();
        @(negedge clk);
        check("arb1_idle", 32'(busy), 32'd0);
        tick();
        ld_valid = 1'b1; rx_start = 1'b1;
        @(negedge clk);
        check("arb2_rx_op", 32'(sr_op), 32'd0);
        tick();
        rx_start = 1'b0;
        b = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            s_in = b[k];
            @(negedge clk);
            check("arb2_rx_shift", 32'({s_out_valid, sr_op}), 32'd1);
            tick();
        end
        repeat (2) begin
            @(negedge clk);
            check("hold_ignore_ld", 32'({ld_ready, sr_op, rx_valid}), 32'd1);
            check("hold_data", 32'(rx_data), 32'h5);
            tick();
        end
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_start = 1'b1;
        @(negedge clk);
        check("arb3_tx_load", 32'(sr_op), 32'd3);
        tick();
        ld_valid = 1'b0; rx_start = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("arb3_idle", 32'(busy), 32'd0);
        tick();

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].is_rx)
                run_rx4(vecs[i].din, vecs[i].dir, vecs[i].exp, (i == 4) ? 3 : 1);
            else
                run_tx4(vecs[i].din, vecs[i].dir, vecs[i].exp);
        end

        // Reset in the middle of a transmission
        ld_valid = 1'b1; ld_data = 4'b1011; tx_dir = 1'b0;
        tick();
        ld_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(s_out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_reg", 32'(rx_data), 32'd0);
        check("midrst_ctrl", 32'({ld_ready, sr_op}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        run_tx4(4'b0110, 1'b0, 4'b0110);

        // WIDTH=8 boundary, both bit orders
        w8 = 8'hA5;
        for (int d = 0; d < 2; d++) begin
            ld_valid8 = 1'b1; ld_data8 = w8; tx_dir8 = 1'(d);
            tick();
            ld_valid8 = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check("w8_valid", 32'(s_out_valid8), 32'd1);
                check("w8_bit", 32'(s_out8), 32'(w8[(d == 1) ? 7 - k : k]));
                tick();
            end
            @(negedge clk);
            check("w8_no_extra", 32'({s_out_valid8, busy8}), 32'd0);
            tick();
        end

        // WIDTH=2 boundary, both bit orders
        w2 = 2'b10;
        for (int d = 0; d < 2; d++) begin
            ld_valid2 = 1'b1; ld_data2 = w2; tx_dir2 = 1'(d);
            tick();
            ld_valid2 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                check("w2_valid", 32'(s_out_valid2), 32'd1);
                check("w2_bit", 32'(s_out2), 32'(w2[(d == 1) ? 1 - k : k]));
                tick();
            end
            @(negedge clk);
            check("w2_no_extra", 32'({s_out_valid2, busy2}), 32'd0);
            tick();
        end

        // Randomized traffic against the transaction-level model
        reset = 1'b1;
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        m_mode = 0; m_last_rx = 1'b1; m_dir = 1'b0; m_word = '0;
        q_tx.delete(); q_rx.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit         take_tx, take_rx;
            logic [1:0] exp_op;
            ld_valid = ($urandom_range(0, 2) != 0);
            rx_start = 1'($urandom_range(0, 1));
            ld_data  = 4'($urandom);
            tx_dir   = 1'($urandom);
            rx_dir   = 1'($urandom);
            s_in     = 1'($urandom);
            rx_ready = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            take_tx = ld_valid && (!rx_start || m_last_rx);
            take_rx = rx_start && !take_tx;
            case (m_mode)
                0:       exp_op = take_tx ? 2'd3 : 2'd0;
                1, 2:    exp_op = m_dir ? 2'd2 : 2'd1;
                default: exp_op = 2'd0;
            endcase
            check("rand_ctrl", 32'({ld_ready, busy, s_out_valid, rx_valid, sr_op}),
                  32'({m_mode == 0, m_mode != 0, m_mode == 1, m_mode == 3, exp_op}));
            if (m_mode == 1) check("rand_s_out", 32'(s_out), 32'(q_tx[0]));
            if (m_mode == 3) check("rand_rx_data", 32'(rx_data), 32'(m_word));
            case (m_mode)
                0: begin
                    if (take_tx) begin
                        for (int k = 0; k < 4; k++) q_tx.push_back(tx_dir ? ld_data[3-k] : ld_data[k]);
                        m_dir  = tx_dir;
                        m_mode = 1;
                    end else if (take_rx) begin
                        q_rx.delete();
                        m_dir  = rx_dir;
                        m_mode = 2;
                    end
                    if (ld_valid && rx_start) m_last_rx = take_rx;
                end
                1: begin
                    void'(q_tx.pop_front());
                    if (q_tx.size() == 0) m_mode = 0;
                end
                2: begin
                    q_rx.push_back(s_in);
                    if (q_rx.size() == 4) begin
                        m_word = '0;
                        for (int k = 0; k < 4; k++) m_word[m_dir ? 3 - k : k] = q_rx[k];
                        m_mode = 3;
                    end
                end
                default: if (rx_ready) m_mode = 0;
            endcase
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
